// File: rtl/lut_builder_pkg.sv
// lut_builder_pkg: state encoding, entry indices and weight codes shared by the LUT builder and LUT_MUX.
package lut_builder_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD0,
      S_ADD1,
      S_ADD2,
      S_ADD3,
      S_ADD4,
      S_ADD5,
      S_PUB
   } state_t;

   localparam int ENTRY_NUM = 8;

   localparam int E0 = 0;
   localparam int E1 = 1;
   localparam int E2 = 2;
   localparam int E3 = 3;
   localparam int E4 = 4;
   localparam int E5 = 5;
   localparam int E6 = 6;
   localparam int E7 = 7;

   localparam logic [3:0] CODE_E0 = 4'b0001;
   localparam logic [3:0] CODE_E1 = 4'b0010;
   localparam logic [3:0] CODE_E2 = 4'b0100;
   localparam logic [3:0] CODE_E3 = 4'b0111;
   localparam logic [3:0] CODE_E4 = 4'b1000;
   localparam logic [3:0] CODE_E5 = 4'b1101;
   localparam logic [3:0] CODE_E6 = 4'b1110;
   localparam logic [3:0] CODE_E7 = 4'b1111;
endpackage

// File: rtl/Signed_Adder.sv
// Signed_Adder: combinational two's-complement adder, the single shared adder of the LUT builder.
module Signed_Adder #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o
);
   assign sum_o = a_i + b_i;
endmodule

// File: rtl/lut_builder.sv
// lut_builder: builds the eight partial-sum LUT entries of one activation group with one shared adder
// and publishes them as a held output bank behind a valid/ready handshake.
module lut_builder
   import lut_builder_pkg::*;
#(
   parameter int ACT_W = 8,
   parameter int LUT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             act_valid_i,
   output logic             act_ready_o,
   input  logic [ACT_W-1:0] act_0_i,
   input  logic [ACT_W-1:0] act_1_i,
   input  logic [ACT_W-1:0] act_2_i,
   input  logic [ACT_W-1:0] act_3_i,
   output logic             lut_valid_o,
   input  logic             lut_ready_i,
   output logic [LUT_W-1:0] lut_0_o,
   output logic [LUT_W-1:0] lut_1_o,
   output logic [LUT_W-1:0] lut_2_o,
   output logic [LUT_W-1:0] lut_3_o,
   output logic [LUT_W-1:0] lut_4_o,
   output logic [LUT_W-1:0] lut_5_o,
   output logic [LUT_W-1:0] lut_6_o,
   output logic [LUT_W-1:0] lut_7_o,
   output logic             busy_o
);
   state_t                  state;
   logic signed [LUT_W-1:0] w [ENTRY_NUM];
   logic signed [LUT_W-1:0] lut_q [ENTRY_NUM];
   logic signed [LUT_W-1:0] tmp, add_a, add_b, sum;

   function automatic logic [LUT_W-1:0] sext(input logic [ACT_W-1:0] a);
      return {{(LUT_W-ACT_W){a[ACT_W-1]}}, a};
   endfunction

   assign act_ready_o = state == S_IDLE;
   assign busy_o      = state != S_IDLE;

   // x3+x2 gets its own slot so one adder suffices; the schedule still ends in S_PUB after six adds.
   always_comb begin
      add_a = state == S_ADD0 ? w[E0] : state == S_ADD2 ? w[E4] : state == S_ADD5 ? w[E6] : tmp;
      add_b = (state == S_ADD0 || state == S_ADD4) ? w[E1] :
              (state == S_ADD1 || state == S_ADD2) ? w[E2] : w[E0];
   end

   Signed_Adder #(.W(LUT_W)) u_add (.a_i(add_a), .b_i(add_b), .sum_o(sum));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= S_IDLE;
         w           <= '{default: '0};
         lut_q       <= '{default: '0};
         tmp         <= '0;
         lut_valid_o <= 1'b0;
      end else begin
         if (lut_valid_o && lut_ready_i) lut_valid_o <= 1'b0;
         case (state)
            S_IDLE: if (act_valid_i) begin
               w[E0] <= sext(act_0_i);
               w[E1] <= sext(act_1_i);
               w[E2] <= sext(act_2_i);
               w[E4] <= sext(act_3_i);
               state <= S_ADD0;
            end
            S_ADD0: begin tmp <= sum; state <= S_ADD1; end
            S_ADD1: begin w[E3] <= sum; state <= S_ADD2; end
            S_ADD2: begin tmp <= sum; state <= S_ADD3; end
            S_ADD3: begin w[E5] <= sum; state <= S_ADD4; end
            S_ADD4: begin w[E6] <= sum; state <= S_ADD5; end
            S_ADD5: begin w[E7] <= sum; state <= S_PUB; end
            S_PUB: if (!lut_valid_o || lut_ready_i) begin
               lut_q       <= w;
               lut_valid_o <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign lut_0_o = lut_q[E0];
   assign lut_1_o = lut_q[E1];
   assign lut_2_o = lut_q[E2];
   assign lut_3_o = lut_q[E3];
   assign lut_4_o = lut_q[E4];
   assign lut_5_o = lut_q[E5];
   assign lut_6_o = lut_q[E6];
   assign lut_7_o = lut_q[E7];
endmodule
